// File: rtl/cell_fuse_loader_if.sv
// cell_fuse_loader_if: handshake and configuration bus between the device
// programming engine (master) and the per-macrocell fuse loader (slave).
//   start_v, abort_v       : frame control from the programmer
//   bit_v, bit_valid_v     : serial fuse data with its valid qualifier
//   bit_ready_v            : loader accepts a bit this cycle
//   readback_v             : committed bit at the index about to be written
//   busy_v, done_v, err_v  : loader status
//   cfg_mux[0:NBITS-1]     : committed mux-select bits consumed by cellcore
interface cell_fuse_loader_if #(
  parameter int NBITS = 20
);
  logic             start_v;
  logic             abort_v;
  logic             bit_v;
  logic             bit_valid_v;
  logic             bit_ready_v;
  logic             readback_v;
  logic             busy_v;
  logic             done_v;
  logic             err_v;
  logic [0:NBITS-1] cfg_mux;

  modport master (
    output start_v, abort_v, bit_v, bit_valid_v,
    input  bit_ready_v, readback_v, busy_v, done_v, err_v, cfg_mux
  );

  modport slave (
    input  start_v, abort_v, bit_v, bit_valid_v,
    output bit_ready_v, readback_v, busy_v, done_v, err_v, cfg_mux
  );
endinterface

// File: rtl/cell_fuse_loader.sv
// cell_fuse_loader: serial fuse loader for one macrocell. Shifts a frame of
// NBITS config bits into a shadow register under a valid/ready handshake and
// commits it atomically onto cfg_mux. Supports abort and an idle timeout.
//   clk_v   : clock, all state changes on the rising edge
//   rstn_v  : synchronous active-low reset
//   bus     : cell_fuse_loader_if.slave (control, serial data, status, cfg_mux)
// Parameters: NBITS (frame length, bit map defined for 20),
//             TIMEOUT (stalled SHIFT cycles before error abort, 0 = off).
// Build option: FUSE_LOADER_PARITY_EN appends an even-parity bit to each
// frame, checked in the COMMIT cycle.
module cell_fuse_loader #(
  parameter int NBITS   = 20,
  parameter int TIMEOUT = 16
) (
  input logic               clk_v,
  input logic               rstn_v,
  cell_fuse_loader_if.slave bus
);
`ifdef FUSE_LOADER_PARITY_EN
  localparam int NTOT = NBITS + 1;
`else
  localparam int NTOT = NBITS;
`endif
  // index must reach NBITS (parity slot) without wrapping
  localparam int IW = $clog2(NBITS + 2);
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [0:NBITS-1] shadow_q, shadow_d;
  logic [0:NBITS-1] cfg_q, cfg_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef FUSE_LOADER_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stall_d  = stall_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef FUSE_LOADER_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start_v) begin
          state_d = SHIFT;
          idx_d   = '0;
          stall_d = '0;
          err_d   = 1'b0;
        end
      end
      SHIFT: begin
        // abort outranks acceptance and timeout
        if (bus.abort_v) begin
          state_d = IDLE;
        end else if (bus.bit_valid_v) begin
          if (idx_q < IW'(NBITS)) shadow_d[idx_q] = bus.bit_v;
`ifdef FUSE_LOADER_PARITY_EN
          else par_d = bus.bit_v;
`endif
          idx_d   = idx_q + IW'(1);
          stall_d = '0;
          if (idx_q == IW'(NTOT - 1)) state_d = COMMIT;
        end else if (TIMEOUT != 0) begin
          if (stall_q == SW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (!bus.abort_v) begin
`ifdef FUSE_LOADER_PARITY_EN
          if ((^shadow_q) ^ par_q) begin
            err_d = 1'b1;
          end else begin
            cfg_d  = shadow_q;
            done_d = 1'b1;
          end
`else
          cfg_d  = shadow_q;
          done_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_v) begin
    if (!rstn_v) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      stall_q  <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FUSE_LOADER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      stall_q  <= stall_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef FUSE_LOADER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.bit_ready_v = (state_q == SHIFT);
  assign bus.busy_v      = (state_q != IDLE);
  assign bus.done_v      = done_q;
  assign bus.err_v       = err_q;
  assign bus.cfg_mux     = cfg_q;
  // verify-before-overwrite: show the committed bit about to be replaced
  assign bus.readback_v  = (state_q == SHIFT && idx_q < IW'(NBITS)) ? cfg_q[idx_q] : 1'b0;
endmodule
